// File: rtl/dag_addr_gen_if.sv
// Sequencer / bus-connect side signals of the data address generator.
// The master side drives the decode and ureg controls; the slave side is the DAG.
interface dag_addr_gen_if #(
  parameter int unsigned DW = 16
);
  logic          ps_dg_en;
  logic          ps_dg_dgsclt;
  logic          ps_dg_mdfy;
  logic [2:0]    ps_dg_iadd;
  logic [2:0]    ps_dg_madd;
  logic          ps_dg_wrt_en;
  logic [4:0]    ps_dg_wrt_add;
  logic [4:0]    ps_dg_rd_add;
  logic [DW-1:0] bc_dt;
  logic [DW-1:0] dg_bc_dt;
  logic [DW-1:0] dg_ps_add;
  logic          dg_add_vld;
  logic          dg_wrap;

  modport master (
    output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
    output ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    input  dg_bc_dt, dg_ps_add, dg_add_vld, dg_wrap
  );

  modport slave (
    input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
    input  ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    output dg_bc_dt, dg_ps_add, dg_add_vld, dg_wrap
  );
endinterface

// File: rtl/dag_addr_gen.sv
// Data address generator: I/M/L/B register file, post/pre-modify and modify-only
// operations with optional circular-buffer wrap, registered address output.
module dag_addr_gen #(
  parameter int unsigned DW      = 16,
  parameter bit          CIRC_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  dag_addr_gen_if.slave dag
);

  logic [DW-1:0] i_q [0:7];
  logic [DW-1:0] m_q [0:7];
  logic [DW-1:0] l_q [0:7];
  logic [DW-1:0] b_q [0:7];

  logic [DW-1:0] add_q;
  logic          vld_q;
  logic          wrap_q;

  logic [DW-1:0] cur_i, cur_m, cur_l, cur_b;
  logic [DW:0]   sum, end_addr;
  logic [DW-1:0] new_i;
  logic          corr;
  logic [DW-1:0] rd_dt;

  assign cur_i = i_q[dag.ps_dg_iadd];
  assign cur_m = m_q[dag.ps_dg_madd];
  assign cur_l = l_q[dag.ps_dg_iadd];
  assign cur_b = b_q[dag.ps_dg_iadd];

  // Sum is one bit wider so the boundary compare sees carries past 2^DW.
  always_comb begin
    sum      = {1'b0, cur_i} + {cur_m[DW-1], cur_m};
    end_addr = {1'b0, cur_b} + {1'b0, cur_l};
    new_i    = sum[DW-1:0];
    corr     = 1'b0;
    if (CIRC_EN && (cur_l != '0)) begin
      if (!cur_m[DW-1] && (sum >= end_addr)) begin
        new_i = sum[DW-1:0] - cur_l;
        corr  = 1'b1;
      end else if (cur_m[DW-1] && (sum < {1'b0, cur_b})) begin
        new_i = sum[DW-1:0] + cur_l;
        corr  = 1'b1;
      end
    end
  end

  always_comb begin
    rd_dt = '0;
    unique case (dag.ps_dg_rd_add[4:3])
      2'b00: rd_dt = i_q[dag.ps_dg_rd_add[2:0]];
      2'b01: rd_dt = m_q[dag.ps_dg_rd_add[2:0]];
      2'b10: rd_dt = l_q[dag.ps_dg_rd_add[2:0]];
      2'b11: rd_dt = b_q[dag.ps_dg_rd_add[2:0]];
      default: rd_dt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
      add_q  <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (dag.ps_dg_en) begin
        wrap_q <= corr;
        if (dag.ps_dg_mdfy) begin
          vld_q                <= 1'b0;
          i_q[dag.ps_dg_iadd]  <= new_i;
        end else begin
          vld_q <= 1'b1;
          if (dag.ps_dg_dgsclt) begin
            add_q <= new_i;
          end else begin
            add_q               <= cur_i;
            i_q[dag.ps_dg_iadd] <= new_i;
          end
        end
      end else begin
        vld_q  <= 1'b0;
        wrap_q <= 1'b0;
      end
      // Placed after the DAG update so a colliding ureg write to In wins.
      if (dag.ps_dg_wrt_en) begin
        unique case (dag.ps_dg_wrt_add[4:3])
          2'b00: i_q[dag.ps_dg_wrt_add[2:0]] <= dag.bc_dt;
          2'b01: m_q[dag.ps_dg_wrt_add[2:0]] <= dag.bc_dt;
          2'b10: l_q[dag.ps_dg_wrt_add[2:0]] <= dag.bc_dt;
          2'b11: begin
            b_q[dag.ps_dg_wrt_add[2:0]] <= dag.bc_dt;
            i_q[dag.ps_dg_wrt_add[2:0]] <= dag.bc_dt;
          end
          default: ;
        endcase
      end
    end
  end

  assign dag.dg_bc_dt   = rd_dt;
  assign dag.dg_ps_add  = add_q;
  assign dag.dg_add_vld = vld_q;
  assign dag.dg_wrap    = wrap_q;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Directed bench for dag_addr_gen: hand-computed vectors covering modify modes,
// circular wrap in both directions, write collision and asynchronous reset.
module tb_dag_addr_gen;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dag_addr_gen_if #(.DW(16)) dag ();

  dag_addr_gen #(
    .DW      (16),
    .CIRC_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dag (dag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    dag.ps_dg_en      = 1'b0;
    dag.ps_dg_dgsclt  = 1'b0;
    dag.ps_dg_mdfy    = 1'b0;
    dag.ps_dg_iadd    = 3'd0;
    dag.ps_dg_madd    = 3'd0;
    dag.ps_dg_wrt_en  = 1'b0;
    dag.ps_dg_wrt_add = 5'd0;
    dag.bc_dt         = 16'h0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [15:0] data);
    dag.ps_dg_wrt_en  = 1'b1;
    dag.ps_dg_wrt_add = addr;
    dag.bc_dt         = data;
    @(posedge clk);
    #1;
    dag.ps_dg_wrt_en  = 1'b0;
  endtask

  // Any ureg write fields set by the caller are applied in the same cycle.
  task automatic op(input logic [2:0] iadd, input logic [2:0] madd,
                    input logic sclt, input logic mdfy);
    dag.ps_dg_en     = 1'b1;
    dag.ps_dg_iadd   = iadd;
    dag.ps_dg_madd   = madd;
    dag.ps_dg_dgsclt = sclt;
    dag.ps_dg_mdfy   = mdfy;
    @(posedge clk);
    #1;
    dag.ps_dg_en     = 1'b0;
    dag.ps_dg_wrt_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [15:0] exp);
    dag.ps_dg_rd_add = addr;
    #1;
    chk(tag, dag.dg_bc_dt, exp);
  endtask

  task automatic out(input string tag, input logic [15:0] addr, input logic vld,
                     input logic wrap);
    chk({tag, "_addr"}, dag.dg_ps_add, addr);
    chk({tag, "_vld"}, {15'h0, dag.dg_add_vld}, {15'h0, vld});
    chk({tag, "_wrap"}, {15'h0, dag.dg_wrap}, {15'h0, wrap});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    clear_ctl();
    dag.ps_dg_rd_add = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    out("reset", 16'h0000, 1'b0, 1'b0);
    rd("reset_i0", 5'h00, 16'h0000);
    rst = 1'b1;

    // Post-modify, linear (L0=0).
    wr(5'h00, 16'h0100);
    wr(5'h09, 16'h0004);
    wr(5'h10, 16'h0000);
    op(3'd0, 3'd1, 1'b0, 1'b0);
    out("post1", 16'h0100, 1'b1, 1'b0);
    op(3'd0, 3'd1, 1'b0, 1'b0);
    out("post2", 16'h0104, 1'b1, 1'b0);
    op(3'd0, 3'd1, 1'b0, 1'b0);
    out("post3", 16'h0108, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    out("idle_hold", 16'h0108, 1'b0, 1'b0);
    rd("post_i0", 5'h00, 16'h010C);

    // Pre-modify with negative M.
    wr(5'h02, 16'h0200);
    wr(5'h0B, 16'hFFFE);
    op(3'd2, 3'd3, 1'b1, 1'b0);
    out("pre", 16'h01FE, 1'b1, 1'b0);
    rd("pre_i2", 5'h02, 16'h0200);

    // Circular forward: B4 write also initialises I4.
    wr(5'h1C, 16'h0040);
    rd("binit_i4", 5'h04, 16'h0040);
    rd("binit_b4", 5'h1C, 16'h0040);
    wr(5'h14, 16'h0005);
    wr(5'h08, 16'h0002);
    op(3'd4, 3'd0, 1'b0, 1'b0);
    out("circ1", 16'h0040, 1'b1, 1'b0);
    op(3'd4, 3'd0, 1'b0, 1'b0);
    out("circ2", 16'h0042, 1'b1, 1'b0);
    op(3'd4, 3'd0, 1'b0, 1'b0);
    out("circ3", 16'h0044, 1'b1, 1'b1);
    op(3'd4, 3'd0, 1'b0, 1'b0);
    out("circ4", 16'h0041, 1'b1, 1'b0);
    rd("circ_i4", 5'h04, 16'h0043);

    // Circular backward.
    wr(5'h1D, 16'h0010);
    wr(5'h15, 16'h0004);
    wr(5'h05, 16'h0010);
    wr(5'h0A, 16'hFFFF);
    op(3'd5, 3'd2, 1'b0, 1'b0);
    out("neg", 16'h0010, 1'b1, 1'b1);
    rd("neg_i5", 5'h05, 16'h0013);

    // Collision: ureg write to I0 wins over the post-modify update.
    wr(5'h00, 16'h0010);
    wr(5'h08, 16'h0001);
    dag.ps_dg_wrt_en  = 1'b1;
    dag.ps_dg_wrt_add = 5'h00;
    dag.bc_dt         = 16'h0055;
    op(3'd0, 3'd0, 1'b0, 1'b0);
    out("coll", 16'h0010, 1'b1, 1'b0);
    rd("coll_i0", 5'h00, 16'h0055);
    op(3'd0, 3'd0, 1'b0, 1'b1);
    out("mdfy", 16'h0010, 1'b0, 1'b0);
    rd("mdfy_i0", 5'h00, 16'h0056);

    // Asynchronous reset in the middle of a circular stream.
    op(3'd4, 3'd0, 1'b0, 1'b0);
    out("pre_rst", 16'h0043, 1'b1, 1'b0);
    dag.ps_dg_en   = 1'b1;
    dag.ps_dg_iadd = 3'd4;
    dag.ps_dg_madd = 3'd0;
    #2;
    rst = 1'b0;
    #1;
    out("rst_mid", 16'h0000, 1'b0, 1'b0);
    for (int a = 0; a < 32; a++) begin
      rd($sformatf("rst_reg%0d", a), a[4:0], 16'h0000);
    end
    clear_ctl();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr(5'h00, 16'h0000);
    op(3'd4, 3'd0, 1'b0, 1'b0);
    out("post_rst", 16'h0000, 1'b1, 1'b0);
    rd("post_rst_i4", 5'h04, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
